// File: rtl/xoodyak_pkg.sv
// Shared constants and types for the Xoodyak hash-mode absorb packer.
package xoodyak_pkg;

  localparam int unsigned RATE_BYTES = 16;
  localparam int unsigned BLK_BYTES  = RATE_BYTES + 1;
  localparam int unsigned LEN_W      = 12;
  localparam int unsigned IDX_W      = 5;

  localparam logic [7:0] PAD_BYTE      = 8'h01;
  localparam logic [7:0] CD_HASH_FIRST = 8'h03;
  localparam logic [7:0] CD_NONE       = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    EMIT
  } state_e;

  // Per-block side information travelling with the padded data
  typedef struct packed {
    logic [IDX_W-1:0] len;
    logic [7:0]       cd;
    logic             last;
  } blk_meta_t;

endpackage

// File: rtl/xoodyak_block_buf.sv
// One padded absorb block (RATE_BYTES + 1 bytes) with byte write, pad insert
// and clear, plus the block's stored len/cd/last.
module xoodyak_block_buf
  import xoodyak_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [7:0]             wr_byte,
  input  logic                   close,
  input  logic [IDX_W-1:0]       pad_idx,
  input  blk_meta_t              meta_in,
  output logic [8*BLK_BYTES-1:0] data,
  output blk_meta_t              meta
);

  logic [BLK_BYTES-1:0][7:0] data_q, data_d;
  blk_meta_t                 meta_q, meta_d;

  // Clear first so a clear and a pad in the same cycle yields a fresh padded block
  always_comb begin
    data_d = clr ? '0 : data_q;
    meta_d = clr ? '0 : meta_q;
    if (wr_en) begin
      data_d[wr_idx] = wr_byte;
    end
    if (close) begin
      data_d[pad_idx] = PAD_BYTE;
      meta_d          = meta_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      meta_q <= '0;
    end else begin
      data_q <= data_d;
      meta_q <= meta_d;
    end
  end

  assign data = data_q;
  assign meta = meta_q;

endmodule

// File: rtl/xoodyak_absorb_packer.sv
// Packs a framed byte stream into padded Xoodyak hash absorb blocks.
// XOODYAK_ABSORB_DBLBUF_EN selects ping-pong buffering instead of a single buffer.
module xoodyak_absorb_packer
  import xoodyak_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LEN_W-1:0]       msg_len,
  input  logic [7:0]             msg,
  input  logic                   msg_valid,
  output logic                   busy,
  output logic [8*BLK_BYTES-1:0] blk_data,
  output logic [7:0]             blk_cd,
  output logic [4:0]             blk_len,
  output logic                   blk_last,
  output logic                   blk_valid,
  input  logic                   blk_ready
);

`ifdef XOODYAK_ABSORB_DBLBUF_EN
  localparam int unsigned NBUF = 2;
`else
  localparam int unsigned NBUF = 1;
`endif

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              first_q, first_d;
  logic              busy_q, busy_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [NBUF-1:0]   full_q, full_d;
  logic [NBUF-1:0]   clr, wr_en, close;
  logic [IDX_W-1:0]  pad_idx;
  blk_meta_t         meta_in;
  logic              accept, handshake;

  logic [8*BLK_BYTES-1:0] buf_data [NBUF];
  blk_meta_t              buf_meta [NBUF];

  // Buffer that follows s in ping-pong order (itself when single-buffered)
  function automatic logic nxt_sel(input logic s);
    return (NBUF == 2) ? ~s : s;
  endfunction

  for (genvar b = 0; b < int'(NBUF); b++) begin : g_buf
    xoodyak_block_buf u_buf (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr[b]),
      .wr_en   (wr_en[b]),
      .wr_idx  (idx_q),
      .wr_byte (msg),
      .close   (close[b]),
      .pad_idx (pad_idx),
      .meta_in (meta_in),
      .data    (buf_data[b]),
      .meta    (buf_meta[b])
    );
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    first_d  = first_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    full_d   = full_q;
    clr      = '0;
    wr_en    = '0;
    close    = '0;
    pad_idx  = idx_q;
    meta_in  = '{len: idx_q, cd: (first_q ? CD_HASH_FIRST : CD_NONE), last: 1'b0};

    accept    = (state_q == FILL) && msg_valid && !busy_q;
    handshake = full_q[rd_sel_q] && blk_ready;

    if (handshake) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = nxt_sel(rd_sel_q);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          rem_d    = msg_len;
          idx_d    = '0;
          first_d  = 1'b1;
          wr_sel_d = 1'b0;
          rd_sel_d = 1'b0;
          clr[0]   = 1'b1;
          // An empty message still absorbs one pad-only block
          if (msg_len == '0) begin
            close[0]  = 1'b1;
            pad_idx   = '0;
            meta_in   = '{len: '0, cd: CD_HASH_FIRST, last: 1'b1};
            full_d[0] = 1'b1;
            state_d   = EMIT;
          end else begin
            state_d = FILL;
          end
        end
      end

      FILL: begin
        if (accept) begin
          wr_en[wr_sel_q] = 1'b1;
          idx_d = (idx_q == IDX_W'(RATE_BYTES)) ? idx_q : idx_q + IDX_W'(1);
          rem_d = (rem_q == '0) ? rem_q : rem_q - LEN_W'(1);
          if ((idx_d == IDX_W'(RATE_BYTES)) || (rem_d == '0)) begin
            close[wr_sel_q]  = 1'b1;
            pad_idx          = idx_d;
            meta_in.len      = idx_d;
            meta_in.last     = (rem_d == '0);
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = nxt_sel(wr_sel_q);
            // Keep filling only when another block's worth of room is free
            if ((rem_d == '0) || full_d[wr_sel_d]) begin
              state_d = EMIT;
            end else begin
              clr[wr_sel_d] = 1'b1;
              idx_d         = '0;
              first_d       = 1'b0;
            end
          end
        end
      end

      EMIT: begin
        if (handshake) begin
          if (buf_meta[rd_sel_q].last) begin
            state_d = IDLE;
          end else if (rem_q != '0) begin
            state_d         = FILL;
            clr[wr_sel_q]   = 1'b1;
            idx_d           = '0;
            first_d         = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != FILL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      idx_q    <= '0;
      first_q  <= 1'b0;
      busy_q   <= 1'b1;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      full_q   <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
      first_q  <= first_d;
      busy_q   <= busy_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      full_q   <= full_d;
    end
  end

  assign busy      = busy_q;
  assign blk_valid = full_q[rd_sel_q];
  assign blk_data  = buf_data[rd_sel_q];
  assign blk_cd    = buf_meta[rd_sel_q].cd;
  assign blk_len   = buf_meta[rd_sel_q].len;
  assign blk_last  = buf_meta[rd_sel_q].last;

endmodule
